bitstream_loader: RTL and testbench

// - Writer side of the program BRAM: takes 32-bit bitstream words from a valid/ready stream
//   (host link or debug bridge) and writes them sequentially into the dual-port BRAM.
// - The fabric programming FSM later reads the BRAM back out.
// - Frames the stream as SYNC word, NWORDS payload words, then a checksum trailer.
// - Pulses prog_req on a clean load so the programming FSM can start without a button press.

---
 rtl/efpga_pkg.sv | 21 ++
 rtl/bitstream_loader.sv | 152 +++++++++++++++
 tb/tb_bitstream_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/efpga_pkg.sv
// Shared types and constants for the eFPGA bitstream loader and the program BRAM.
package efpga_pkg;

  // Loader frame states: SYNC, LOAD and CHECK are the "busy" states.
  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LOAD,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  // Marker that opens every bitstream frame.
  localparam logic [31:0] SYNC_WORD = 32'hAA995566;

  // Default BRAM geometry, shared by the loader, the BRAM and the programming FSM.
  localparam int DEFAULT_ADDR_W = 11;
  localparam int DEFAULT_NWORDS = 1357;

endpackage

// File: rtl/bitstream_loader.sv
// Writer side of the program BRAM: frames a valid/ready word stream as
// SYNC word, NWORDS payload words and a checksum trailer, writes the payload
// into BRAM port A and pulses prog_req when a frame checks out clean.
module bitstream_loader
  import efpga_pkg::*;
#(
  parameter int          ADDR_W    = DEFAULT_ADDR_W,
  parameter int          NWORDS    = DEFAULT_NWORDS,   // must not exceed 2**ADDR_W
  parameter logic [31:0] SYNC_WORD = efpga_pkg::SYNC_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              prog_req
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NWORDS - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              prog_req_q, prog_req_d;

  logic              in_frame;
  logic              accept;
  logic [31:0]       check_sum;

  // Ready depends on state alone so the upstream never sees a valid->ready loop.
  assign in_frame  = (state_q == SYNC) || (state_q == LOAD) || (state_q == CHECK);
  assign s_ready   = in_frame;
  assign busy      = in_frame;
  // An abort in the same cycle swallows the word: not written, not summed.
  assign accept    = s_valid && in_frame && !abort;
  assign check_sum = sum_q + s_data;

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign done      = done_q;
  assign error     = error_q;
  assign prog_req  = prog_req_q;

  // Next-state logic for the frame FSM; abort beats arm and beats an accepted word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (arm) state_d = SYNC;
      SYNC: begin
        if (abort)                                 state_d = IDLE;
        else if (accept && (s_data == SYNC_WORD))  state_d = LOAD;
      end
      LOAD: begin
        if (abort)                                 state_d = IDLE;
        else if (accept && (cnt_q == LAST_IDX))    state_d = CHECK;
      end
      CHECK: begin
        if (abort)                                 state_d = IDLE;
        else if (accept)                           state_d = (check_sum == 32'd0) ? DONE : ERR;
      end
      DONE, ERR: if (arm) state_d = SYNC;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: word counter, running checksum, one-cycle-late BRAM write register and status flags.
  always_comb begin
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    done_d     = done_q;
    error_d    = error_q;
    prog_req_d = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (arm) begin
          cnt_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          din_d  = s_data;
          sum_d  = check_sum;
          // Counter parks on the last index instead of wrapping.
          if (cnt_q != LAST_IDX) cnt_d = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (accept) begin
          if (check_sum == 32'd0) begin
            done_d     = 1'b1;
            prog_req_d = 1'b1;
          end else begin
            error_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (abort && in_frame) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  // State and datapath registers; reset clears everything except BRAM contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      prog_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      done_q     <= done_d;
      error_q    <= error_d;
      prog_req_q <= prog_req_d;
    end
  end

endmodule

// File: tb/tb_bitstream_loader.sv
// Self-checking bench for bitstream_loader: table of whole-frame vectors plus
// hand-written abort / reset / simultaneous-event sequences. Expected BRAM writes
// are queued as payload is driven and popped when the DUT writes.
module tb_bitstream_loader;
  import efpga_pkg::*;

  localparam int ADDR_W = DEFAULT_ADDR_W;
  localparam int NW     = DEFAULT_NWORDS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_data = '0;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_din;
  logic              busy;
  logic              done;
  logic              error;
  logic              prog_req;

  bitstream_loader #(.ADDR_W(ADDR_W), .NWORDS(NW), .SYNC_WORD(SYNC_WORD)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .done(done), .error(error), .prog_req(prog_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    string       name;
    int          junk;
    logic [31:0] toff;
    bit          thr;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          prog_cnt = 0;
  int          ready_miss = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // BRAM model and scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (prog_req === 1'b1) prog_cnt++;
    if (bram_we === 1'b1) begin
      wr_cnt++;
      mem[bram_addr] = bram_din;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write addr=%0d data=%0h expected no write", bram_addr, bram_din);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bram_addr), e.addr);
        chk("wr_data", bram_din, e.data);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit pay, input int idx, input bit thr);
    while (thr && ($urandom_range(0, 99) < 30)) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      tick();
    end
    s_valid = 1'b1;
    s_data  = w;
    if (s_ready !== 1'b1) ready_miss++;
    if (pay) exp_q.push_back('{32'(idx), w});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [31:0] sum;
    int p0, w0, bad;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hDEADBEEF;
    p0 = prog_cnt;
    w0 = wr_cnt;
    ready_miss = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk({v.name, "_armed_busy"}, 32'(busy), 32'd1);
    chk({v.name, "_armed_flags"}, 32'({done, error}), 32'd0);
    if (v.junk > 0) send(32'h0, 1'b0, 0, v.thr);
    if (v.junk > 1) send(32'h12345678, 1'b0, 0, v.thr);
    send(SYNC_WORD, 1'b0, 0, v.thr);
    sum = '0;
    for (int i = 0; i < NW; i++) begin
      sum = sum + 32'(i + 1);
      send(32'(i + 1), 1'b1, i, v.thr);
    end
    send((~sum + 32'd1) + v.toff, 1'b0, 0, v.thr);
    chk({v.name, "_prog_req_entry"}, 32'(prog_req), 32'(v.exp_done));
    tick();
    chk({v.name, "_prog_req_len"}, 32'(prog_req), 32'd0);
    tick();
    chk({v.name, "_done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, "_error"}, 32'(error), 32'(v.exp_err));
    chk({v.name, "_ready_after"}, 32'(s_ready), 32'd0);
    chk({v.name, "_busy_after"}, 32'(busy), 32'd0);
    chk({v.name, "_prog_pulses"}, 32'(prog_cnt - p0), 32'(v.exp_done));
    chk({v.name, "_writes"}, 32'(wr_cnt - w0), 32'(NW));
    chk({v.name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({v.name, "_ready_drops"}, 32'(ready_miss), 32'd0);
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== 32'(i + 1)) bad++;
    chk({v.name, "_bram_bad_words"}, 32'(bad), 32'd0);
    $display("frame %s: done=%0b error=%0b writes=%0d prog=%0d", v.name, done, error,
             wr_cnt - w0, prog_cnt - p0);
  endtask

  // Arm, sync and push n payload words, leaving the loader mid-LOAD.
  task automatic partial_frame(input int n);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    send(SYNC_WORD, 1'b0, 0, 1'b0);
    for (int i = 0; i < n; i++) send(32'(i + 1), 1'b1, i, 1'b0);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t nominal;
    int w0;
    vecs[0] = '{"nominal",   0, 32'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"junk",      2, 32'd0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"badsum",    0, 32'd1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"throttled", 0, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{"rearm",     0, 32'd0, 1'b0, 1'b1, 1'b0};
    nominal = vecs[0];

    reset = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 32'({s_ready, bram_we, bram_addr, bram_din != 32'd0, busy, done, error, prog_req}), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(s_ready), 32'd0);
    $display("reset: outputs idle");

    for (int k = 0; k < 5; k++) run_frame(vecs[k]);

    // Abort after 100 payload words.
    w0 = wr_cnt;
    partial_frame(100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_ready", 32'(s_ready), 32'd0);
    chk("abort_flags", 32'({done, error}), 32'd0);
    repeat (3) tick();
    chk("abort_writes", 32'(wr_cnt - w0), 32'd100);
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    $display("abort: writes=%0d busy=%0b", wr_cnt - w0, busy);
    run_frame(nominal);

    // Reset after 100 payload words.
    w0 = wr_cnt;
    partial_frame(100);
    reset = 1'b1;
    tick();
    chk("midreset_outputs", 32'({s_ready, bram_we, bram_addr, bram_din != 32'd0, busy, done, error, prog_req}), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    chk("midreset_writes", 32'(wr_cnt - w0), 32'd100);
    chk("midreset_pending", 32'(exp_q.size()), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    $display("reset mid-frame: writes=%0d busy=%0b", wr_cnt - w0, busy);
    run_frame(nominal);

    // Abort, arm and an accepted word all in one LOAD cycle.
    w0 = wr_cnt;
    partial_frame(5);
    s_valid = 1'b1;
    s_data  = 32'hBAD0BAD0;
    arm     = 1'b1;
    abort   = 1'b1;
    tick();
    s_valid = 1'b0;
    arm     = 1'b0;
    abort   = 1'b0;
    chk("simul_busy", 32'(busy), 32'd0);
    chk("simul_ready", 32'(s_ready), 32'd0);
    repeat (3) tick();
    chk("simul_still_idle", 32'(busy), 32'd0);
    chk("simul_writes", 32'(wr_cnt - w0), 32'd5);
    chk("simul_pending", 32'(exp_q.size()), 32'd0);
    chk("simul_flags", 32'({done, error, prog_req}), 32'd0);
    $display("simultaneous abort/arm/word: writes=%0d busy=%0b", wr_cnt - w0, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
